// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core, debug and bank-array bus bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 13
);
    logic              core_req_i;
    logic              core_we_i;
    logic [3:0]        core_be_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [31:0]       core_wdata_i;
    logic              core_gnt_o;
    logic              core_stall_o;
    logic              core_rvalid_o;
    logic [31:0]       core_rdata_o;

    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [3:0]        dbg_be_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [31:0]       dbg_wdata_i;
    logic              dbg_gnt_o;
    logic              dbg_rvalid_o;
    logic [31:0]       dbg_rdata_o;

    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
        output core_gnt_o, core_stall_o, core_rvalid_o, core_rdata_o,
        input  dbg_req_i, dbg_we_i, dbg_be_i, dbg_addr_i, dbg_wdata_i,
        output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
        input  core_gnt_o, core_stall_o, core_rvalid_o, core_rdata_o,
        output dbg_req_i, dbg_we_i, dbg_be_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core-priority data memory arbiter with debug starvation guard (optional DMEM_ARB_STATS_EN conflict counter)
module dmem_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0] conflict_cnt_o
`endif
);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0]  wait_cnt;
    logic              force_dbg;
    logic              core_gnt;
    logic              dbg_gnt;
    logic              rd_core;
    logic              rd_dbg;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    // Grant: core wins unless debug has already lost MAX_WAIT cycles in a row; nothing is granted in reset
    always_comb begin
        force_dbg = bus.dbg_req_i & (wait_cnt == WAIT_LIMIT);
        dbg_gnt   = ~rst_i & bus.dbg_req_i & (~bus.core_req_i | force_dbg);
        core_gnt  = ~rst_i & bus.core_req_i & ~dbg_gnt;
    end

    // Bank-side mux: the winner drives the banks in its grant cycle, idle bus is all-zero
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (core_gnt) begin
            mem_en    = 1'b1;
            mem_we    = bus.core_be_i & {4{bus.core_we_i}};
            mem_addr  = bus.core_addr_i;
            mem_wdata = bus.core_wdata_i;
        end else if (dbg_gnt) begin
            mem_en    = 1'b1;
            mem_we    = bus.dbg_be_i & {4{bus.dbg_we_i}};
            mem_addr  = bus.dbg_addr_i;
            mem_wdata = bus.dbg_wdata_i;
        end
    end

    assign bus.core_gnt_o    = core_gnt;
    assign bus.dbg_gnt_o     = dbg_gnt;
    assign bus.core_stall_o  = bus.core_req_i & ~core_gnt;
    assign bus.mem_en_o      = mem_en;
    assign bus.mem_we_o      = mem_we;
    assign bus.mem_addr_o    = mem_addr;
    assign bus.mem_wdata_o   = mem_wdata;
    assign bus.core_rvalid_o = rd_core;
    assign bus.dbg_rvalid_o  = rd_dbg;
    assign bus.core_rdata_o  = bus.mem_rdata_i;
    assign bus.dbg_rdata_o   = bus.mem_rdata_i;

    // Starvation counter: counts consecutive cycles a pending debug request loses, saturating at the limit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (!bus.dbg_req_i || dbg_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Read owner: remembers who issued a load so the 1-cycle bank data is steered to the right rvalid
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_core <= 1'b0;
            rd_dbg  <= 1'b0;
        end else begin
            rd_core <= core_gnt & ~bus.core_we_i;
            rd_dbg  <= dbg_gnt & ~bus.dbg_we_i;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Conflict statistics: cycles where both requesters want the banks, saturating
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_cnt_o <= 16'h0;
        end else if (bus.core_req_i && bus.dbg_req_i && conflict_cnt_o != 16'hFFFF) begin
            conflict_cnt_o <= conflict_cnt_o + 16'h1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    localparam int ADDR_W   = 13;
    localparam int MAX_WAIT = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt_o;
`endif

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
`ifdef DMEM_ARB_STATS_EN
        ,
        .conflict_cnt_o (conflict_cnt_o)
`endif
    );

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Reference model state: consecutive debug losses, pending read owners, conflict count
    int losses = 0;
    bit m_rv_core = 0;
    bit m_rv_dbg  = 0;
    int m_conf    = 0;
    bit m_cg, m_dg;

    function automatic void model_grants();
        m_dg = !rst_i && bus.dbg_req_i && (!bus.core_req_i || losses == MAX_WAIT);
        m_cg = !rst_i && bus.core_req_i && !m_dg;
    endfunction

    function automatic void model_update();
        if (rst_i) begin
            losses = 0; m_rv_core = 0; m_rv_dbg = 0; m_conf = 0;
        end else begin
            m_rv_core = m_cg && !bus.core_we_i;
            m_rv_dbg  = m_dg && !bus.dbg_we_i;
            if (bus.dbg_req_i && !m_dg) losses = (losses < MAX_WAIT) ? losses + 1 : MAX_WAIT;
            else losses = 0;
            if (bus.core_req_i && bus.dbg_req_i && m_conf < 65535) m_conf++;
        end
    endfunction

    task automatic tick();
        model_grants();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        bus.core_req_i = 0; bus.core_we_i = 0; bus.core_be_i = 0; bus.core_addr_i = 0; bus.core_wdata_i = 0;
        bus.dbg_req_i = 0; bus.dbg_we_i = 0; bus.dbg_be_i = 0; bus.dbg_addr_i = 0; bus.dbg_wdata_i = 0;
    endtask

    task automatic test_reset();
        set_idle();
        bus.mem_rdata_i = 32'h0;
        rst_i = 1;
        bus.core_req_i = 1;
        bus.dbg_req_i = 1;
        #4;
        check_cnt++; if (bus.core_gnt_o !== 1'b0) $display("FAIL rst_core_gnt: got %b want 0", bus.core_gnt_o); else pass_cnt++;
        check_cnt++; if (bus.dbg_gnt_o !== 1'b0) $display("FAIL rst_dbg_gnt: got %b want 0", bus.dbg_gnt_o); else pass_cnt++;
        check_cnt++; if (bus.mem_en_o !== 1'b0) $display("FAIL rst_mem_en: got %b want 0", bus.mem_en_o); else pass_cnt++;
        check_cnt++; if (bus.core_stall_o !== 1'b1) $display("FAIL rst_stall: got %b want 1", bus.core_stall_o); else pass_cnt++;
        tick();
        tick();
        set_idle();
        rst_i = 0;
        #4;
        check_cnt++; if (bus.core_rvalid_o !== 1'b0 || bus.dbg_rvalid_o !== 1'b0)
            $display("FAIL rst_rvalid: got %b%b want 00", bus.core_rvalid_o, bus.dbg_rvalid_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_core_load();
        logic [31:0] rd;
        set_idle();
        bus.core_req_i = 1; bus.core_we_i = 0; bus.core_be_i = 4'hF; bus.core_addr_i = 13'h010;
        #4;
        check_cnt++; if (bus.core_gnt_o !== 1'b1) $display("FAIL load_gnt: got %b want 1", bus.core_gnt_o); else pass_cnt++;
        check_cnt++; if (bus.mem_en_o !== 1'b1 || bus.mem_addr_o !== 13'h010 || bus.mem_we_o !== 4'h0)
            $display("FAIL load_mem: got en=%b addr=%h we=%h want en=1 addr=010 we=0", bus.mem_en_o, bus.mem_addr_o, bus.mem_we_o); else pass_cnt++;
        tick();
        set_idle();
        rd = $urandom;
        bus.mem_rdata_i = rd;
        #4;
        check_cnt++; if (bus.core_rvalid_o !== 1'b1 || bus.dbg_rvalid_o !== 1'b0)
            $display("FAIL load_rvalid: got core=%b dbg=%b want core=1 dbg=0", bus.core_rvalid_o, bus.dbg_rvalid_o); else pass_cnt++;
        check_cnt++; if (bus.core_rdata_o !== rd) $display("FAIL load_rdata: got %h want %h", bus.core_rdata_o, rd); else pass_cnt++;
        tick();
    endtask

    task automatic test_dbg_store();
        set_idle();
        bus.dbg_req_i = 1; bus.dbg_we_i = 1; bus.dbg_be_i = 4'b0100;
        bus.dbg_wdata_i = 32'h00AB0000; bus.dbg_addr_i = 13'h1FFF;
        #4;
        check_cnt++; if (bus.dbg_gnt_o !== 1'b1 || bus.core_gnt_o !== 1'b0)
            $display("FAIL store_gnt: got dbg=%b core=%b want dbg=1 core=0", bus.dbg_gnt_o, bus.core_gnt_o); else pass_cnt++;
        check_cnt++; if (bus.mem_we_o !== 4'b0100 || bus.mem_addr_o !== 13'h1FFF || bus.mem_wdata_o !== 32'h00AB0000)
            $display("FAIL store_mem: got we=%b addr=%h wdata=%h want 0100 1fff 00ab0000", bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o); else pass_cnt++;
        tick();
        set_idle();
        #4;
        check_cnt++; if (bus.core_rvalid_o !== 1'b0 || bus.dbg_rvalid_o !== 1'b0)
            $display("FAIL store_rvalid: got %b%b want 00", bus.core_rvalid_o, bus.dbg_rvalid_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_contention();
        bit exp_d;
        set_idle();
        tick();
        bus.core_req_i = 1; bus.core_addr_i = 13'h005;
        bus.dbg_req_i = 1; bus.dbg_addr_i = 13'h00A;
        for (int c = 0; c < 10; c++) begin
            #4;
            exp_d = (c % 5 == 4);
            check_cnt++; if (bus.dbg_gnt_o !== exp_d || bus.core_gnt_o !== !exp_d || bus.core_stall_o !== exp_d)
                $display("FAIL contention_c%0d: got dbg=%b core=%b stall=%b want dbg=%b core=%b stall=%b",
                         c, bus.dbg_gnt_o, bus.core_gnt_o, bus.core_stall_o, exp_d, !exp_d, exp_d);
            else pass_cnt++;
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic test_dbg_drop();
        bit exp_d;
        set_idle();
        tick();
        bus.core_req_i = 1; bus.dbg_req_i = 1;
        tick();
        tick();
        bus.dbg_req_i = 0;
        tick();
        bus.dbg_req_i = 1;
        for (int c = 0; c < 5; c++) begin
            #4;
            exp_d = (c == 4);
            check_cnt++; if (bus.dbg_gnt_o !== exp_d || bus.core_gnt_o !== !exp_d)
                $display("FAIL drop_c%0d: got dbg=%b core=%b want dbg=%b", c, bus.dbg_gnt_o, bus.core_gnt_o, exp_d);
            else pass_cnt++;
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra, rb;
        ra = $urandom; rb = $urandom;
        set_idle();
        bus.core_req_i = 1; bus.core_we_i = 0; bus.core_addr_i = 13'h001;
        #4;
        check_cnt++; if (bus.core_gnt_o !== 1'b1 || bus.mem_addr_o !== 13'h001)
            $display("FAIL b2b_core_gnt: got gnt=%b addr=%h want 1 001", bus.core_gnt_o, bus.mem_addr_o); else pass_cnt++;
        tick();
        set_idle();
        bus.dbg_req_i = 1; bus.dbg_we_i = 0; bus.dbg_addr_i = 13'h002;
        bus.mem_rdata_i = ra;
        #4;
        check_cnt++; if (bus.core_rvalid_o !== 1'b1 || bus.dbg_rvalid_o !== 1'b0 || bus.core_rdata_o !== ra)
            $display("FAIL b2b_cyc1: got crv=%b drv=%b data=%h want 1 0 %h", bus.core_rvalid_o, bus.dbg_rvalid_o, bus.core_rdata_o, ra); else pass_cnt++;
        check_cnt++; if (bus.dbg_gnt_o !== 1'b1 || bus.mem_addr_o !== 13'h002)
            $display("FAIL b2b_dbg_gnt: got gnt=%b addr=%h want 1 002", bus.dbg_gnt_o, bus.mem_addr_o); else pass_cnt++;
        tick();
        set_idle();
        bus.mem_rdata_i = rb;
        #4;
        check_cnt++; if (bus.core_rvalid_o !== 1'b0 || bus.dbg_rvalid_o !== 1'b1 || bus.dbg_rdata_o !== rb)
            $display("FAIL b2b_cyc2: got crv=%b drv=%b data=%h want 0 1 %h", bus.core_rvalid_o, bus.dbg_rvalid_o, bus.dbg_rdata_o, rb); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_read();
        set_idle();
        bus.core_req_i = 1; bus.dbg_req_i = 1; bus.core_we_i = 0; bus.core_addr_i = 13'h0AA;
        tick();
        set_idle();
        rst_i = 1;
        #4;
        check_cnt++; if (bus.core_rvalid_o !== 1'b1)
            $display("FAIL rstmid_pending: got %b want 1", bus.core_rvalid_o); else pass_cnt++;
        tick();
        rst_i = 0;
        #4;
        check_cnt++; if (bus.core_rvalid_o !== 1'b0 || bus.dbg_rvalid_o !== 1'b0)
            $display("FAIL rstmid_rvalid: got %b%b want 00", bus.core_rvalid_o, bus.dbg_rvalid_o); else pass_cnt++;
`ifdef DMEM_ARB_STATS_EN
        check_cnt++; if (conflict_cnt_o !== 16'h0)
            $display("FAIL rstmid_conflict: got %0d want 0", conflict_cnt_o); else pass_cnt++;
`endif
        tick();
    endtask

    task automatic test_random();
        logic [3:0] exp_we;
        logic [ADDR_W-1:0] exp_addr;
        logic [31:0] exp_wdata;
        for (int n = 0; n < 400; n++) begin
            rst_i = ($urandom_range(0, 59) == 0);
            bus.core_req_i = ($urandom_range(0, 9) < 6);
            bus.core_we_i = $urandom; bus.core_be_i = $urandom;
            bus.core_addr_i = $urandom; bus.core_wdata_i = $urandom;
            bus.dbg_req_i = ($urandom_range(0, 9) < 7);
            bus.dbg_we_i = $urandom; bus.dbg_be_i = $urandom;
            bus.dbg_addr_i = $urandom; bus.dbg_wdata_i = $urandom;
            bus.mem_rdata_i = $urandom;
            #4;
            model_grants();
            exp_we = 4'h0; exp_addr = '0; exp_wdata = 32'h0;
            if (m_cg) begin
                exp_we = bus.core_we_i ? bus.core_be_i : 4'h0;
                exp_addr = bus.core_addr_i; exp_wdata = bus.core_wdata_i;
            end else if (m_dg) begin
                exp_we = bus.dbg_we_i ? bus.dbg_be_i : 4'h0;
                exp_addr = bus.dbg_addr_i; exp_wdata = bus.dbg_wdata_i;
            end
            check_cnt++; if (bus.core_gnt_o !== m_cg || bus.dbg_gnt_o !== m_dg || bus.core_stall_o !== (bus.core_req_i && !m_cg))
                $display("FAIL rand_gnt n=%0d: got core=%b dbg=%b stall=%b want %b %b %b", n,
                         bus.core_gnt_o, bus.dbg_gnt_o, bus.core_stall_o, m_cg, m_dg, bus.core_req_i && !m_cg);
            else pass_cnt++;
            check_cnt++; if (bus.mem_en_o !== (m_cg || m_dg) || bus.mem_we_o !== exp_we || bus.mem_addr_o !== exp_addr || bus.mem_wdata_o !== exp_wdata)
                $display("FAIL rand_mem n=%0d: got en=%b we=%h addr=%h wd=%h want %b %h %h %h", n,
                         bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, m_cg || m_dg, exp_we, exp_addr, exp_wdata);
            else pass_cnt++;
            check_cnt++; if (bus.core_rvalid_o !== m_rv_core || bus.dbg_rvalid_o !== m_rv_dbg)
                $display("FAIL rand_rvalid n=%0d: got %b%b want %b%b", n, bus.core_rvalid_o, bus.dbg_rvalid_o, m_rv_core, m_rv_dbg);
            else pass_cnt++;
            if (m_rv_core || m_rv_dbg) begin
                check_cnt++; if ((m_rv_core && bus.core_rdata_o !== bus.mem_rdata_i) || (m_rv_dbg && bus.dbg_rdata_o !== bus.mem_rdata_i))
                    $display("FAIL rand_rdata n=%0d: got core=%h dbg=%h want %h", n, bus.core_rdata_o, bus.dbg_rdata_o, bus.mem_rdata_i);
                else pass_cnt++;
            end
`ifdef DMEM_ARB_STATS_EN
            check_cnt++; if (conflict_cnt_o !== 16'(m_conf))
                $display("FAIL rand_conflict n=%0d: got %0d want %0d", n, conflict_cnt_o, m_conf);
            else pass_cnt++;
`endif
            tick();
        end
        rst_i = 0;
        set_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_core_load();
        test_dbg_store();
        test_contention();
        test_dbg_drop();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Arbitrates the 4-bank byte-lane data memory (8 KiB words x 4 byte banks, 1-cycle synchronous read) between two requesters. The requesters are the core load/store port and a debug/loader port used by the verification environment and boot loader. It sits between the MEM stage and the bank array, and drives the core stall when the core loses arbitration. Core has priority; a starvation counter guarantees the debug port forward progress.

Parameters:
ADDR_W, 13, word-address width into each bank (memory_address = byte_addr[ADDR_W+1:2])
MAX_WAIT, 4, max consecutive cycles a pending debug request may lose to the core before forced grant (1..15)
CNT_W, 4, width of the starvation counter; must hold MAX_WAIT

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
core_req_i  in  1  core access request; held stable until core_gnt_o
core_we_i  in  1  1=store, 0=load
core_be_i  in  4  byte enables (bank0..bank3), already aligned by MEM stage
core_addr_i  in  ADDR_W  word address
core_wdata_i  in  32  lane-aligned store data
core_gnt_o  out  1  core access issued this cycle
core_stall_o  out  1  core_req_i & ~core_gnt_o
core_rvalid_o  out  1  core load data valid (1 cycle after grant of a load)
core_rdata_o  out  32  read data
dbg_req_i  in  1  debug access request; held stable until dbg_gnt_o
dbg_we_i  in  1  1=write, 0=read
dbg_be_i  in  4  byte enables
dbg_addr_i  in  ADDR_W  word address
dbg_wdata_i  in  32  write data
dbg_gnt_o  out  1  debug access issued this cycle
dbg_rvalid_o  out  1  debug read data valid
dbg_rdata_o  out  32  read data
mem_en_o  out  1  bank enable (shared by all 4 banks)
mem_we_o  out  4  per-bank write enable
mem_addr_o  out  ADDR_W  bank address
mem_wdata_o  out  32  {din3,din2,din1,din0}
mem_rdata_i  in  32  {dout3,dout2,dout1,dout0}

Behaviour:
- Grant decision is combinational from the current requests and the registered wait_cnt. Exactly one grant or none per cycle.
- force_dbg = dbg_req_i & (wait_cnt == MAX_WAIT).
- dbg_gnt_o = dbg_req_i & (~core_req_i | force_dbg).
- core_gnt_o = core_req_i & ~dbg_gnt_o.
- Memory mux, same cycle as grant: the granted requester's addr/wdata drive mem_*. mem_en_o = core_gnt_o | dbg_gnt_o. mem_we_o = be & {4{we}} of the winner. With no grant, mem_en_o=0, mem_we_o=0, addr/wdata=0.
- wait_cnt (CNT_W, registered):
  - cleared when dbg_req_i=0 or dbg_gnt_o=1;
  - otherwise incremented, saturating at MAX_WAIT.
- Read return: owner register {rd_core, rd_dbg} is loaded each cycle with {core_gnt_o & ~core_we_i, dbg_gnt_o & ~dbg_we_i}.
  - core_rvalid_o = rd_core and dbg_rvalid_o = rd_dbg, both registered, one cycle after grant.
  - core_rdata_o = dbg_rdata_o = mem_rdata_i (pass-through). Only meaningful while the matching rvalid is high.
- Writes produce no rvalid. A write with be=4'b0000 is granted but writes nothing.
- Back-to-back: a new grant is allowed every cycle. A read granted in cycle N returns in N+1 while cycle N+1's access is issued.
- Simultaneous requests below MAX_WAIT: core wins, debug waits, core_stall_o=0.
- At wait_cnt==MAX_WAIT: debug wins. core_stall_o=1 for exactly that cycle, then wait_cnt=0.
- Reset (synchronous), including mid-read: wait_cnt=0, rd_core=rd_dbg=0, so core_rvalid_o=dbg_rvalid_o=0 from the next cycle on. In-flight read data is discarded. Combinational outputs follow the inputs; while rst_i=1, grants are forced to 0 (mem_en_o=0, mem_we_o=0, core_stall_o=core_req_i).

Optional Feature:
DMEM_ARB_STATS_EN
- Defined: adds output conflict_cnt_o [15:0]. It increments, saturating at 16'hFFFF, on every cycle where core_req_i & dbg_req_i. It resets to 0 on rst_i.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Core load only: core_req=1, we=0, addr=0x010 -> mem_en=1, mem_addr=0x010, core_gnt=1 same cycle; core_rvalid=1 next cycle with core_rdata=mem_rdata_i; dbg_rvalid=0.
- Debug store alone: dbg_req=1, we=1, be=4'b0100, wdata=0x00AB0000, addr=0x1FFF -> mem_we=4'b0100, mem_addr=0x1FFF, dbg_gnt=1, no rvalid.
- Contention, MAX_WAIT=4: core_req and dbg_req held high continuously -> core granted cycles 0-3, dbg granted cycle 4 (core_stall=1 only in cycle 4), core granted cycles 5-8, dbg in cycle 9; repeating period 5.
- Debug drops request at wait_cnt=2 and re-raises it -> counter restarts from 0; dbg gets a forced grant only after 4 further losing cycles.
- Back-to-back reads core A=0x001, then dbg B=0x002 -> core_rvalid in cycle 1, dbg_rvalid in cycle 2, never both high together.
- rst_i asserted in the cycle after a core read grant -> core_rvalid=0 in the following cycle, wait_cnt=0; with DMEM_ARB_STATS_EN, conflict_cnt_o=0.
